// File: rtl/slave_core_sequencer.sv
// slave_core_sequencer: launch/run/drain sequencer for a slave core.
// Walks IDLE -> CLEAR -> LOAD -> RUN -> DRAIN -> DONE.
// Each launch clears the core, then loads the PC, then lets the pipeline run.
// The run ends on halt. The sequencer then waits for outstanding memory
// traffic to finish and signals completion with a one-cycle pulse.
// Optional feature macro: SLAVE_WATCHDOG_EN. When it is defined, a RUN-cycle
// watchdog ends runaway programs and flags timeout.
`ifndef PcWidth
`define PcWidth 16
`endif

module slave_core_sequencer #(
    parameter int unsigned CLR_CYCLES = 4,
    parameter int unsigned WDT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_start,
    input  logic [`PcWidth-1:0]  cpu_start_adr,
    input  logic                 halt,
    input  logic                 mem_busy,
    output logic                 cpu_end,
    output logic                 core_run,
    output logic                 core_clr,
    output logic                 pc_load,
    output logic [`PcWidth-1:0]  pc_load_val,
    output logic                 busy,
    output logic                 start_err,
    output logic                 timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Last value of the clear counter before leaving CLEAR.
    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

    state_t               state_q;
    logic [3:0]           clr_cnt_q;
    logic                 cpu_end_q;
    logic                 core_run_q;
    logic                 core_clr_q;
    logic                 pc_load_q;
    logic [`PcWidth-1:0]  pc_load_val_q;
    logic                 busy_q;
    logic                 start_err_q;
    logic                 timeout_q;

    // A start arriving in any of the working states is ignored and flagged.
    logic start_while_busy;
    assign start_while_busy = cpu_start &&
                              ((state_q == S_CLEAR) || (state_q == S_LOAD) ||
                               (state_q == S_RUN)   || (state_q == S_DRAIN));

`ifdef SLAVE_WATCHDOG_EN
    localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);
    logic [15:0] wdt_cnt_q;
`else
    // The watchdog limit has no effect when the watchdog is compiled out.
    logic unused_wdt;
    assign unused_wdt = ^16'(WDT_CYCLES);
`endif

    // Sequencer FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            clr_cnt_q     <= '0;
            cpu_end_q     <= 1'b0;
            core_run_q    <= 1'b0;
            core_clr_q    <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_load_val_q <= '0;
            busy_q        <= 1'b0;
            start_err_q   <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef SLAVE_WATCHDOG_EN
            wdt_cnt_q     <= '0;
`endif
        end else begin
            // One-cycle pulses drop by default.
            cpu_end_q <= 1'b0;
            pc_load_q <= 1'b0;

            if (start_while_busy) begin
                start_err_q <= 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (cpu_start) begin
                        state_q       <= S_CLEAR;
                        clr_cnt_q     <= '0;
                        core_clr_q    <= 1'b1;
                        pc_load_val_q <= cpu_start_adr;
                        busy_q        <= 1'b1;
                        timeout_q     <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q    <= S_LOAD;
                        core_clr_q <= 1'b0;
                        pc_load_q  <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 4'd1;
                    end
                end
                S_LOAD: begin
                    state_q    <= S_RUN;
                    core_run_q <= 1'b1;
`ifdef SLAVE_WATCHDOG_EN
                    wdt_cnt_q  <= '0;
`endif
                end
                S_RUN: begin
                    if (halt) begin
                        // A real halt wins over a watchdog expiry in the same cycle.
                        state_q    <= S_DRAIN;
                        core_run_q <= 1'b0;
                    end
`ifdef SLAVE_WATCHDOG_EN
                    else if (wdt_cnt_q == WDT_LAST) begin
                        state_q    <= S_DRAIN;
                        core_run_q <= 1'b0;
                        timeout_q  <= 1'b1;
                    end else begin
                        wdt_cnt_q <= wdt_cnt_q + 16'd1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (!mem_busy) begin
                        state_q   <= S_DONE;
                        cpu_end_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (cpu_start) begin
                        // Back-to-back launch: skip IDLE and clear immediately.
                        state_q       <= S_CLEAR;
                        clr_cnt_q     <= '0;
                        core_clr_q    <= 1'b1;
                        pc_load_val_q <= cpu_start_adr;
                        timeout_q     <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    core_run_q <= 1'b0;
                    core_clr_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_end     = cpu_end_q;
    assign core_run    = core_run_q;
    // Reset also clears the core, so a reset during a run wipes its state.
    assign core_clr    = core_clr_q | rst;
    assign pc_load     = pc_load_q;
    assign pc_load_val = pc_load_val_q;
    assign busy        = busy_q;
    assign start_err   = start_err_q;
`ifdef SLAVE_WATCHDOG_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule
